// File: rtl/drac_pkg.sv
// Shared types for the execute-stage divider sequencer: FSM states and the
// latched request record.
package drac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } div_ctrl_state_t;

  typedef struct packed {
    logic        int32;
    logic        signed_op;
    logic        rem;
    logic [63:0] dvnd;
    logic [63:0] dvsr;
  } div_req_t;

endpackage

// File: rtl/div_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from an internal pointer,
// which moves just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] idx;
  logic [PW-1:0] gid;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    gid   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gid        = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (int'(gid) == N - 1) ? '0 : gid + PW'(1);
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer/arbiter for the shared iterative divider, with a one-entry
// operand cache so a DIV/REM pair on the same operands runs the divider once.
module div_ctrl
  import drac_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0]       req_int32_i,
  input  logic [NUM_REQ-1:0]       req_signed_i,
  input  logic [NUM_REQ-1:0]       req_rem_i,
  input  logic [NUM_REQ-1:0][63:0] req_dvnd_i,
  input  logic [NUM_REQ-1:0][63:0] req_dvsr_i,
  input  logic [NUM_REQ-1:0]       kill_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [63:0]              rsp_data_o,
  output logic                     div_request_o,
  output logic                     div_kill_o,
  output logic                     div_int32_o,
  output logic                     div_signed_o,
  output logic [63:0]              div_dvnd_o,
  output logic [63:0]              div_dvsr_o,
  input  logic [63:0]              div_quo_i,
  input  logic [63:0]              div_rmd_i,
  input  logic                     div_stall_i
);

  div_ctrl_state_t state_q, state_d;
  div_req_t        op_q, req_sel;
  logic [ID_W-1:0] owner_q, grant_id;
  logic [NUM_REQ-1:0] arb_req;
  logic handshake, owner_kill, cache_hit, result_cycle;

  logic        cache_valid_q, cache_int32_q, cache_signed_q;
  logic [63:0] cache_dvnd_q, cache_dvsr_q, cache_quo_q, cache_rmd_q;

  // Killed requesters are masked so a flushed op is never granted.
  assign arb_req = (state_q == IDLE) ? (req_valid_i & ~kill_i) : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .req     (arb_req),
    .advance (handshake),
    .grant   (req_ready_o)
  );

  assign handshake = |(req_valid_i & req_ready_o);

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready_o[i]) grant_id = ID_W'(i);
    end
  end

  always_comb begin
    req_sel.int32     = req_int32_i[grant_id];
    req_sel.signed_op = req_signed_i[grant_id];
    req_sel.rem       = req_rem_i[grant_id];
    req_sel.dvnd      = req_dvnd_i[grant_id];
    req_sel.dvsr      = req_dvsr_i[grant_id];
  end

  assign cache_hit = cache_valid_q && (req_sel.dvnd == cache_dvnd_q) &&
                     (req_sel.dvsr == cache_dvsr_q) &&
                     (req_sel.int32 == cache_int32_q) &&
                     (req_sel.signed_op == cache_signed_q);

  assign owner_kill   = kill_i[owner_q];
  assign result_cycle = (state_q == BUSY) && !div_stall_i && !owner_kill;

  // The divider samples these pins in its result cycle, so they come straight
  // from the latch and only change on the next handshake.
  assign div_int32_o  = op_q.int32;
  assign div_signed_o = op_q.signed_op;
  assign div_dvnd_o   = op_q.dvnd;
  assign div_dvsr_o   = op_q.dvsr;
  assign rsp_id_o     = owner_q;
  assign rsp_valid_o  = (state_q == RESP) && !owner_kill;

  always_comb begin
    state_d       = state_q;
    div_request_o = 1'b0;
    div_kill_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake) state_d = cache_hit ? RESP : ISSUE;
      end
      ISSUE: begin
        if (owner_kill) begin
          div_kill_o = 1'b1;
          state_d    = IDLE;
        end else begin
          div_request_o = 1'b1;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (owner_kill) begin
          div_kill_o = 1'b1;
          state_d    = IDLE;
        end else if (!div_stall_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (owner_kill || rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      op_q       <= '0;
      owner_q    <= '0;
      rsp_data_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && handshake) begin
        op_q    <= req_sel;
        owner_q <= grant_id;
        if (cache_hit) rsp_data_o <= req_sel.rem ? cache_rmd_q : cache_quo_q;
      end
      if (result_cycle) rsp_data_o <= op_q.rem ? div_rmd_i : div_quo_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cache_valid_q  <= 1'b0;
      cache_int32_q  <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_dvnd_q   <= '0;
      cache_dvsr_q   <= '0;
      cache_quo_q    <= '0;
      cache_rmd_q    <= '0;
    end else if (result_cycle) begin
      cache_valid_q  <= 1'b1;
      cache_int32_q  <= op_q.int32;
      cache_signed_q <= op_q.signed_op;
      cache_dvnd_q   <= op_q.dvnd;
      cache_dvsr_q   <= op_q.dvsr;
      cache_quo_q    <= div_quo_i;
      cache_rmd_q    <= div_rmd_i;
    end
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer and arbiter for the shared iterative `div_unit` in the execute stage. Accepts divide/remainder requests from `NUM_REQ` requesters, grants round-robin, drives the divider's request/kill/operand pins, and holds them stable through the result cycle. Returns results over a valid/ready channel. A one-entry operand cache lets DIV/REM pairs on identical operands complete without re-running the divider.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2).
- `ID_W`, `$clog2(NUM_REQ)`: requester index width.
- `clk_i` in 1: clock.
- `rstn_i` in 1: reset. Asynchronous, active-low.
- `req_valid_i` in NUM_REQ: request pending, per requester.
- `req_ready_o` out NUM_REQ: one-hot grant. Handshake occurs when valid & ready.
- `req_int32_i` in NUM_REQ: W-form (32-bit) op.
- `req_signed_i` in NUM_REQ: signed op.
- `req_rem_i` in NUM_REQ: return the remainder (else the quotient).
- `req_dvnd_i` in NUM_REQ×64: dividend (rs1).
- `req_dvsr_i` in NUM_REQ×64: divisor (rs2).
- `kill_i` in NUM_REQ: flush of the requester's in-flight op.
- `rsp_valid_o` out 1: result valid.
- `rsp_ready_i` in 1: consumer accepts the result.
- `rsp_id_o` out ID_W: owning requester.
- `rsp_data_o` out 64: result.
- `div_request_o` out 1: to divider `request_i`.
- `div_kill_o` out 1: to divider `kill_div_i`.
- `div_int32_o` out 1: to divider `int_32_i`.
- `div_signed_o` out 1: to divider `signed_op_i`.
- `div_dvnd_o` out 64: to divider `dvnd_i`.
- `div_dvsr_o` out 64: to divider `dvsr_i`.
- `div_quo_i` in 64: from divider `quo_o`.
- `div_rmd_i` in 64: from divider `rmd_o`.
- `div_stall_i` in 1: from divider `stall_o`.

## Operation
- **States:** IDLE, ISSUE, BUSY, RESP. Reset enters IDLE.
  - Reset clears all registered outputs, the operand latch, the cache valid bit and the RR pointer to 0.
  - `req_ready_o` is combinational and is 0 outside IDLE.
- **IDLE:** the round-robin arbiter grants among requesters with `req_valid_i & ~kill_i`, starting from the pointer. On a handshake:
  - Latch id, int32, signed, rem, dvnd, dvsr.
  - Set pointer = granted id + 1 (mod NUM_REQ).
  - On a cache hit (dvnd, dvsr, int32 and signed all equal the cached key, and cache valid), load `rsp_data_o` from the cached quo/rmd selected by rem, then go to RESP. Otherwise go to ISSUE.
- **ISSUE:** `div_request_o`=1 for exactly this cycle, then go to BUSY.
- **BUSY:** `div_request_o`=0. The first cycle with `div_stall_i`=0 is the divider's result cycle. In that cycle:
  - Capture `div_quo_i`/`div_rmd_i` into the cache.
  - Set the cache key and cache valid.
  - Load `rsp_data_o` (rmd if rem, else quo).
  - Go to RESP.
- **Operand/mode hold:** `div_int32_o`, `div_signed_o`, `div_dvnd_o` and `div_dvsr_o` come from the latch. They stay stable from ISSUE through the result cycle, because the divider forms its outputs from these pins in that cycle.
- **RESP:** `rsp_valid_o`=1 and `rsp_id_o`/`rsp_data_o` are held stable until `rsp_ready_i`=1, then go to IDLE. There is no same-cycle re-grant.
- **Kill** (only `kill_i[owner]` acts; kills to other requesters are ignored):
  - In ISSUE: `div_request_o` is suppressed and `div_kill_o`=1. Go to IDLE with no response.
  - In BUSY: `div_kill_o`=1 for one cycle. Go to IDLE, no response, cache unchanged. A kill in the result cycle takes precedence over capture.
  - In RESP: drop `rsp_valid_o` and go to IDLE. The cache keeps the completed result.
- **Data rules:**
  - Divide-by-zero and signed overflow results pass through from the divider unmodified.
  - W-form results arrive already sign-extended.
  - Cache compare uses the full 64-bit operands.

## Timing
- Handshake at cycle t.
  - ISSUE at t+1. Divider iterates t+2..t+33 (64-bit) or t+2..t+17 (32-bit).
  - Result cycle at t+34 (64-bit) or t+18 (32-bit).
  - `rsp_valid_o` at t+35 (64-bit) or t+19 (32-bit).
- Cache hit: `rsp_valid_o` at t+1, divider untouched.
- Back-to-back: a response accepted at cycle r allows the next handshake at r+1.

## Structure
- Shared package (`drac_pkg`): `div_ctrl_state_t` enum and a `div_req_t` struct {int32, signed, rem, dvnd, dvsr}.
- Sub-module `rr_arbiter` with parameter N, inputs req and advance, output one-hot grant, and an internal pointer.
- Instantiated by the exe stage alongside `div_unit`.

## Test plan
- Req0 DIVU 100/7, 64-bit, handshake at t=0 → `div_request_o` at t=1; `rsp_valid_o` at t=35 with id=0, data=14.
- Req1 REMW signed −7/2 (dvnd=0xFFFFFFFFFFFFFFF9) → `rsp_valid_o` at t=19, data=0xFFFFFFFFFFFFFFFF.
- DIV 100/7 followed by REM 100/7 from req1 → second response 1 cycle after its handshake, data=2, no `div_request_o`.
- Both requesters valid continuously, pointer=0 → grants alternate 0,1,0,1. Responses are held while `rsp_ready_i`=0 for 5 cycles.
- Kill:
  - `kill_i[0]` at t+10 of a 64-bit op → `div_kill_o` pulses, no response, IDLE at t+11.
  - A following identical request misses the cache and takes the full latency.
- `rstn_i` low mid-BUSY → all outputs 0, cache invalid; the next request runs the full latency.
